iq_stream_dequant: RTL and testbench

IQ_STREAM_DEQUANT -- requirements
Module: iq_stream_dequant

---
 rtl/iq_stream_dequant.sv | 173 +++++++++++++++++
 tb/tb_iq_stream_dequant.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_stream_dequant.sv
// Streaming inverse quantiser: per-block qp/size latch, two-stage scale/round/clip
// datapath with valid/ready flow control and a per-block nonzero coefficient count.
//
// state | meaning
// IDLE  | waiting for start; qp range checked here
// RUN   | accepting input beats until the block's last beat is taken
// FLUSH | input closed; draining the pipeline until out_last handshakes
// DONE  | one-cycle done pulse; nz_count already published
module iq_stream_dequant #(
    parameter int COEFF_WIDTH = 16,
    parameter int QP_WIDTH    = 6,
    parameter int BIT_DEPTH   = 8,
    parameter int LANES       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   log2_size_m2,
    input  logic [QP_WIDTH-1:0]          qp,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*COEFF_WIDTH-1:0] in_coeff,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*COEFF_WIDTH-1:0] out_coeff,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [10:0]                  nz_count
);
    localparam int CW         = COEFF_WIDTH;
    localparam int PW         = COEFF_WIDTH + 20;
    localparam int LANES_LOG2 = $clog2(LANES);
    localparam longint MAXL   = (64'sd1 <<< (CW - 1)) - 1;
    localparam logic signed [PW-1:0] MAXV = PW'(MAXL);
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;
    state_t state, state_nxt;

    logic        advance, in_hs, out_hs, qp_legal, start_ok;
    logic [6:0]  scale_new, scale_q;
    logic [3:0]  qshift_new, qshift_q;
    logic [1:0]  size_q;
    logic [4:0]  bd_shift;
    logic [10:0] beats_total, beats_left, nz_acc;
    int          qp_i;

    logic                 s1_valid, s1_last;
    logic signed [PW-1:0] s1_p   [LANES];
    logic signed [PW-1:0] p_next [LANES];
    logic signed [PW-1:0] r      [LANES];
    logic signed [PW-1:0] rnd;
    logic [LANES*CW-1:0]  c_packed;
    logic [2:0]           nz_next, out_nz;

    assign advance  = !out_valid || out_ready;
    assign in_ready = (state == ST_RUN) && advance;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign qp_legal = (qp <= QP_WIDTH'(51));
    assign start_ok = (state == ST_IDLE) && start && qp_legal;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    assign beats_total = (11'd16 << {log2_size_m2, 1'b0}) >> LANES_LOG2;
    assign bd_shift    = 5'(BIT_DEPTH - 3) + {3'b000, size_q};
    assign rnd         = PW'(1) << (bd_shift - 5'd1);

    always_comb begin
        qp_i       = int'(qp);
        qshift_new = 4'(qp_i / 6);
        scale_new  = 7'd40;
        case (qp_i % 6)
            1:       scale_new = 7'd45;
            2:       scale_new = 7'd51;
            3:       scale_new = 7'd57;
            4:       scale_new = 7'd64;
            5:       scale_new = 7'd72;
            default: scale_new = 7'd40;
        endcase
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            p_next[k] = (PW'($signed(in_coeff[k*CW +: CW]))
                         * $signed({{(PW-11){1'b0}}, scale_q, 4'b0000})) <<< qshift_q;
        end
    end

    // Round-half-up then arithmetic (floor) shift, saturate to the coefficient range.
    always_comb begin
        c_packed = '0;
        nz_next  = '0;
        for (int k = 0; k < LANES; k++) begin
            r[k] = (s1_p[k] + rnd) >>> bd_shift;
            if (r[k] > MAXV)
                c_packed[k*CW +: CW] = MAXV[CW-1:0];
            else if (r[k] < MINV)
                c_packed[k*CW +: CW] = MINV[CW-1:0];
            else
                c_packed[k*CW +: CW] = r[k][CW-1:0];
            if (c_packed[k*CW +: CW] != '0)
                nz_next = nz_next + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            for (int k = 0; k < LANES; k++) s1_p[k] <= '0;
            out_valid <= 1'b0;
            out_coeff <= '0;
            out_last  <= 1'b0;
            out_nz    <= '0;
        end else if (advance) begin
            s1_valid <= in_hs;
            if (in_hs) begin
                for (int k = 0; k < LANES; k++) s1_p[k] <= p_next[k];
                s1_last <= (beats_left == '0);
            end
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            if (s1_valid) begin
                out_coeff <= c_packed;
                out_nz    <= nz_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            scale_q    <= 7'd40;
            qshift_q   <= '0;
            size_q     <= '0;
            beats_left <= '0;
            nz_acc     <= '0;
            nz_count   <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= (state == ST_IDLE) && start && !qp_legal;
            if (start_ok) begin
                scale_q    <= scale_new;
                qshift_q   <= qshift_new;
                size_q     <= log2_size_m2;
                beats_left <= beats_total - 11'd1;
                nz_acc     <= '0;
            end else begin
                if (in_hs && beats_left != '0)
                    beats_left <= beats_left - 11'd1;
                if (out_hs)
                    nz_acc <= nz_acc + {8'b0, out_nz};
                if (state == ST_FLUSH && out_hs && out_last)
                    nz_count <= nz_acc + {8'b0, out_nz};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
            ST_RUN:   if (in_hs && beats_left == '0) state_nxt = ST_FLUSH;
            ST_FLUSH: if (out_hs && out_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_iq_stream_dequant.sv
// Randomised bench for iq_stream_dequant against an arithmetic reference model
// of the dequantisation rule, with a per-block expected-beat queue.
module tb_iq_stream_dequant;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  log2_size_m2;
    logic [5:0]  qp;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_coeff;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_coeff;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] nz_count;

    int checks = 0;
    int errors = 0;
    logic [63:0] first_beat;
    int          last_nz;
    logic [15:0] pat [4] = '{16'd1, 16'hFFFF, 16'd100, 16'd0};

    always #5 clk = ~clk;

    iq_stream_dequant dut (
        .clk(clk), .reset(reset), .start(start), .log2_size_m2(log2_size_m2), .qp(qp),
        .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
        .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
        .out_last(out_last), .busy(busy), .done(done), .err(err), .nz_count(nz_count)
    );

    function automatic longint model_dq(longint level, int qpv, int sz);
        longint scale, p, r;
        int bd;
        case (qpv % 6)
            0: scale = 40;
            1: scale = 45;
            2: scale = 51;
            3: scale = 57;
            4: scale = 64;
            default: scale = 72;
        endcase
        p  = level * 16 * scale * (longint'(1) << (qpv / 6));
        bd = 8 + sz - 3;
        r  = (p + (longint'(1) << (bd - 1))) >>> bd;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic logic [63:0] gen_beat(int mode);
        logic [63:0] b;
        int sel;
        b = '0;
        for (int k = 0; k < 4; k++) begin
            if (mode == 0) b[k*16 +: 16] = 16'd1;
            else if (mode == 1) b[k*16 +: 16] = pat[k];
            else begin
                sel = $urandom_range(9);
                if (sel < 3) b[k*16 +: 16] = 16'd0;
                else if (sel == 3) b[k*16 +: 16] = 16'($urandom());
                else b[k*16 +: 16] = 16'($urandom_range(400)) - 16'd200;
            end
        end
        return b;
    endfunction

    task automatic run_block(input int sz, input int qpv, input int mode,
                             input int stall_pct, input int gap_pct, input int mid_qp);
        int beats, sent, recv, cyc, limit, first_in, first_out, last_out, exp_nz;
        bit seen_done, stalled_prev, hs_prev, mid_done;
        logic [63:0] exp_q[$];
        logic [63:0] cur_in, prev_out, e;
        logic prev_last;
        longint v;
        beats = (16 << (2 * sz)) / 4;
        sent = 0; recv = 0; cyc = 0; first_in = -1; first_out = -1; last_out = -1;
        exp_nz = 0; seen_done = 0; stalled_prev = 0; mid_done = 0;
        limit = beats * 12 + 200;
        @(posedge clk); #1;
        start = 1'b1; qp = 6'(qpv); log2_size_m2 = 2'(sz); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cur_in = gen_beat(mode);
        in_coeff = cur_in;
        in_valid = ($urandom_range(99) >= gap_pct);
        out_ready = ($urandom_range(99) >= stall_pct);
        while (!seen_done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_block actual=%b required=1", busy); end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_stall actual=%b required=0", in_ready); end
            end
            if (stalled_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_coeff !== prev_out || out_last !== prev_last) begin
                    errors++;
                    $display("FAIL hold_stall actual=%b/%h/%b required=1/%h/%b",
                             out_valid, out_coeff, out_last, prev_out, prev_last);
                end
            end
            hs_prev = in_valid && in_ready;
            if (hs_prev) begin
                if (sent >= beats) begin
                    checks++; errors++;
                    $display("FAIL extra_in_beat actual=%0d required=%0d", sent + 1, beats);
                end else begin
                    e = '0;
                    for (int k = 0; k < 4; k++) begin
                        v = model_dq(longint'($signed(cur_in[k*16 +: 16])), qpv, sz);
                        e[k*16 +: 16] = 16'(v);
                        if (v != 0) exp_nz++;
                    end
                    exp_q.push_back(e);
                end
                if (first_in < 0) first_in = cyc;
                sent++;
            end
            if (out_valid && first_out < 0) first_out = cyc;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL out_unexpected actual=%h required=none", out_coeff);
                end else begin
                    e = exp_q.pop_front();
                    if (out_coeff !== e) begin
                        errors++; $display("FAIL out_coeff beat=%0d actual=%h required=%h", recv, out_coeff, e);
                    end
                end
                checks++;
                if (out_last !== (recv == beats - 1)) begin
                    errors++; $display("FAIL out_last beat=%0d actual=%b required=%b", recv, out_last, recv == beats - 1);
                end
                if (recv == 0) first_beat = out_coeff;
                recv++;
                last_out = cyc;
            end
            if (done) begin
                seen_done = 1;
                checks++;
                if (last_out != cyc - 1) begin
                    errors++; $display("FAIL done_timing actual=%0d required=%0d", cyc, last_out + 1);
                end
                checks++;
                if (nz_count !== 11'(exp_nz)) begin
                    errors++; $display("FAIL nz_count actual=%0d required=%0d", nz_count, exp_nz);
                end
            end
            stalled_prev = out_valid && !out_ready;
            prev_out = out_coeff;
            prev_last = out_last;
            @(posedge clk); #1;
            if (hs_prev || !in_valid) begin
                cur_in = gen_beat(mode);
                if (sent >= beats) cur_in = {$urandom(), $urandom()};
                in_valid = (sent >= beats) ? 1'b1 : ($urandom_range(99) >= gap_pct);
            end
            in_coeff = in_valid ? cur_in : {$urandom(), $urandom()};
            out_ready = ($urandom_range(99) >= stall_pct);
            start = 1'b0;
            if (mid_qp >= 0 && sent >= 2 && !mid_done) begin
                start = 1'b1; qp = 6'(mid_qp); mid_done = 1;
            end
        end
        checks++;
        if (!seen_done) begin errors++; $display("FAIL block_timeout actual=%0d cycles required=done", cyc); end
        checks++;
        if (recv != beats || exp_q.size() != 0) begin
            errors++; $display("FAIL beat_count actual=%0d required=%0d", recv, beats);
        end
        if (stall_pct == 0 && gap_pct == 0) begin
            checks++;
            if (first_out - first_in != 2) begin
                errors++; $display("FAIL latency actual=%0d required=2", first_out - first_in);
            end
            checks++;
            if (last_out - first_in != beats + 1) begin
                errors++; $display("FAIL throughput actual=%0d required=%0d", last_out - first_in, beats + 1);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL back_to_idle actual=%b/%b required=0/0", busy, done);
        end
        last_nz = exp_nz;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_last, busy, done, err} !== 6'b0 || out_coeff !== 64'd0 || nz_count !== 11'd0) begin
            errors++;
            $display("FAIL reset_state actual=%b%b%b%b%b%b/%h/%0d required=000000/0/0",
                     in_ready, out_valid, out_last, busy, done, err, out_coeff, nz_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic_4x4();
        logic [63:0] want;
        want = {4{16'd20}};
        run_block(0, 0, 0, 0, 0, -1);
        checks++;
        if (first_beat !== want) begin errors++; $display("FAIL basic_value actual=%h required=%h", first_beat, want); end
        checks++;
        if (nz_count !== 11'd16) begin errors++; $display("FAIL basic_nz actual=%0d required=16", nz_count); end
    endtask

    task automatic test_max_qp_32x32();
        logic [63:0] want;
        want = {16'h0000, 16'h7FFF, 16'hFC70, 16'h0390};
        run_block(3, 51, 1, 0, 0, -1);
        checks++;
        if (first_beat !== want) begin errors++; $display("FAIL maxqp_value actual=%h required=%h", first_beat, want); end
        checks++;
        if (nz_count !== 11'd768) begin errors++; $display("FAIL maxqp_nz actual=%0d required=768", nz_count); end
    endtask

    task automatic test_err();
        logic [10:0] nz_before;
        nz_before = nz_count;
        @(posedge clk); #1;
        start = 1'b1; qp = 6'd52; log2_size_m2 = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL err_pulse actual=%b/%b required=1/0", err, busy);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_width actual=%b required=0", err); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL err_idle actual=%b/%b required=0/0", out_valid, busy);
            end
        end
        checks++;
        if (nz_count !== nz_before) begin errors++; $display("FAIL err_nz actual=%0d required=%0d", nz_count, nz_before); end
    endtask

    task automatic test_random_stall();
        for (int i = 0; i < 3; i++) run_block(1, int'($urandom_range(51)), 2, 40, 30, -1);
        run_block(2, int'($urandom_range(51)), 2, 25, 20, -1);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1'b1; qp = 6'd20; log2_size_m2 = 2'd2;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            in_coeff = gen_beat(2);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_run_active actual=%b/%b required=1/1", busy, out_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, busy, done, err} !== 6'b0 || out_coeff !== 64'd0 || nz_count !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset_state actual=%b%b%b%b%b%b/%h/%0d required=000000/0/0",
                     in_ready, out_valid, out_last, busy, done, err, out_coeff, nz_count);
        end
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        run_block(0, 7, 2, 10, 10, -1);
    endtask

    task automatic test_start_ignored();
        run_block(0, 10, 2, 20, 10, 45);
        run_block(1, 3, 2, 0, 0, 50);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; log2_size_m2 = '0; qp = '0;
        in_valid = 1'b0; in_coeff = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic_4x4();
        test_max_qp_32x32();
        test_err();
        test_random_stall();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
